// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-to-WB pipeline bus.
// The mem_* signals are what the memory stage hands over; the wb_* signals are
// the registered copies presented to write-back (and, for LLbit, back to MEM
// as its bypass).
// Modports:
//   master - memory-stage side: drives mem_*, observes wb_*
//   slave  - pipeline register (mem_wb): reads mem_*, drives wb_*
interface mem_wb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    // Memory-stage requests
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_hi;
    logic [DATA_W-1:0] mem_lo;
    logic              mem_whilo;
    logic              mem_LLbit_we;
    logic              mem_LLbit_value;

    // Registered write-back view
    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_whilo;
    logic              wb_LLbit_we;
    logic              wb_LLbit_value;

    modport master (
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_LLbit_we, mem_LLbit_value,
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value
    );

    modport slave (
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_LLbit_we, mem_LLbit_value,
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value
    );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register merged with the architectural LLbit.
// Captures register-file, HI/LO and LLbit write requests from MEM, presents
// them to WB one cycle later, and commits a pending LLbit write the cycle
// after that. Honours the stall vector and the exception flush.
// Optional feature macro: MEM_WB_LLBIT_EN (LLbit path present when defined;
// otherwise wb_LLbit_* and LLbit_o are tied to 0 and no LLbit flops exist).
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset
//   stall   - stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
//   flush   - exception/ERET flush
//   bus     - mem_wb_if.slave: mem_* requests in, registered wb_* out
//   LLbit_o - committed LLbit
module mem_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    mem_wb_if.slave    bus,
    output logic       LLbit_o
);

    // Bubble when flushing, or when MEM stalls while WB keeps moving.
    logic bubble_c;
    logic load_c;

    assign bubble_c = flush | (stall[4] & ~stall[5]);
    assign load_c   = ~stall[4];

    // Register-file and HI/LO write requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wb_wd    <= ADDR_W'(0);
            bus.wb_wreg  <= 1'b0;
            bus.wb_wdata <= DATA_W'(0);
            bus.wb_hi    <= DATA_W'(0);
            bus.wb_lo    <= DATA_W'(0);
            bus.wb_whilo <= 1'b0;
        end else if (bubble_c) begin
            bus.wb_wd    <= ADDR_W'(0);
            bus.wb_wreg  <= 1'b0;
            bus.wb_wdata <= DATA_W'(0);
            bus.wb_hi    <= DATA_W'(0);
            bus.wb_lo    <= DATA_W'(0);
            bus.wb_whilo <= 1'b0;
        end else if (load_c) begin
            bus.wb_wd    <= bus.mem_wd;
            bus.wb_wreg  <= bus.mem_wreg;
            bus.wb_wdata <= bus.mem_wdata;
            bus.wb_hi    <= bus.mem_hi;
            bus.wb_lo    <= bus.mem_lo;
            bus.wb_whilo <= bus.mem_whilo;
        end
    end

`ifdef MEM_WB_LLBIT_EN
    // LLbit write request staged alongside the other WB fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.wb_LLbit_we    <= 1'b0;
            bus.wb_LLbit_value <= 1'b0;
        end else if (bubble_c) begin
            bus.wb_LLbit_we    <= 1'b0;
            bus.wb_LLbit_value <= 1'b0;
        end else if (load_c) begin
            bus.wb_LLbit_we    <= bus.mem_LLbit_we;
            bus.wb_LLbit_value <= bus.mem_LLbit_value;
        end
    end

    // Architectural LLbit: a request already in WB commits even under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LLbit_o <= 1'b0;
        end else if (flush) begin
            LLbit_o <= 1'b0;
        end else if (bus.wb_LLbit_we) begin
            LLbit_o <= bus.wb_LLbit_value;
        end
    end

    logic unused_stall;
    assign unused_stall = ^stall[3:0];
`else
    // LLbit path absent: constant outputs, MEM LLbit requests ignored.
    assign bus.wb_LLbit_we    = 1'b0;
    assign bus.wb_LLbit_value = 1'b0;
    assign LLbit_o            = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{stall[3:0], bus.mem_LLbit_we, bus.mem_LLbit_value};
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed scoreboard bench for mem_wb.
// A driver applies one vector per cycle on the falling edge and pushes the
// hand-computed post-edge response; a monitor pops and compares just after
// each rising edge. LLbit expectations collapse to 0 when MEM_WB_LLBIT_EN is
// not defined.
module tb_mem_wb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

`ifdef MEM_WB_LLBIT_EN
    localparam logic LL_EN = 1'b1;
`else
    localparam logic LL_EN = 1'b0;
`endif

    typedef struct {
        logic              rst;
        logic [5:0]        stall;
        logic              flush;
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
        logic              llwe;
        logic              llval;
    } stim_t;

    typedef struct {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
        logic              llwe;
        logic              llval;
        logic              llbit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] stall = 6'b0;
    logic       flush = 1'b0;
    logic       llbit;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .bus     (bus),
        .LLbit_o (llbit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".wb_wd"},          32'(bus.wb_wd),          32'(e.wd));
        chk({tag, ".wb_wreg"},        32'(bus.wb_wreg),        32'(e.wreg));
        chk({tag, ".wb_wdata"},       bus.wb_wdata,            e.wdata);
        chk({tag, ".wb_hi"},          bus.wb_hi,               e.hi);
        chk({tag, ".wb_lo"},          bus.wb_lo,               e.lo);
        chk({tag, ".wb_whilo"},       32'(bus.wb_whilo),       32'(e.whilo));
        chk({tag, ".wb_LLbit_we"},    32'(bus.wb_LLbit_we),    32'(e.llwe));
        chk({tag, ".wb_LLbit_value"}, 32'(bus.wb_LLbit_value), 32'(e.llval));
        chk({tag, ".LLbit_o"},        32'(llbit),              32'(e.llbit));
    endtask

    // Apply one vector on the falling edge and queue its post-edge response.
    task automatic step(input stim_t s, input exp_t e);
        exp_t zero;
        zero = '{default: '0};
        @(negedge clk);
        rst              = s.rst;
        stall            = s.stall;
        flush            = s.flush;
        bus.mem_wd       = s.wd;
        bus.mem_wreg     = s.wreg;
        bus.mem_wdata    = s.wdata;
        bus.mem_hi       = s.hi;
        bus.mem_lo       = s.lo;
        bus.mem_whilo    = s.whilo;
        bus.mem_LLbit_we = s.llwe;
        bus.mem_LLbit_value = s.llval;
        e.llwe  = e.llwe  & LL_EN;
        e.llval = e.llval & LL_EN;
        e.llbit = e.llbit & LL_EN;
        sb_q.push_back(e);
        if (!s.rst) begin
            // Asynchronous reset must clear outputs before any clock edge.
            #1;
            compare_all("async_rst", zero);
        end
    endtask

    // Monitor: one expected response per rising edge once vectors start.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare_all("edge", e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t zero;
        zero = '{default: '0};
        bus.mem_wd = '0; bus.mem_wreg = 1'b0; bus.mem_wdata = '0;
        bus.mem_hi = '0; bus.mem_lo = '0; bus.mem_whilo = 1'b0;
        bus.mem_LLbit_we = 1'b0; bus.mem_LLbit_value = 1'b0;
        #1;
        compare_all("reset_state", zero);
        repeat (2) @(negedge clk);

        // Pass-through
        step('{1'b1, 6'b000000, 1'b0, 5'd5, 1'b1, 32'h12345678, 32'hAAAA0001, 32'h55550002, 1'b1, 1'b0, 1'b0},
             '{5'd5, 1'b1, 32'h12345678, 32'hAAAA0001, 32'h55550002, 1'b1, 1'b0, 1'b0, 1'b0});
        // MEM stalled, WB running: bubble
        step('{1'b1, 6'b010000, 1'b0, 5'd7, 1'b1, 32'hCAFEF00D, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        // LL request enters WB
        step('{1'b1, 6'b000000, 1'b0, 5'd9, 1'b1, 32'hDEADBEEF, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1},
             '{5'd9, 1'b1, 32'hDEADBEEF, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0});
        // Both stalled: hold; LLbit commits regardless of stall
        step('{1'b1, 6'b110000, 1'b0, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0},
             '{5'd9, 1'b1, 32'hDEADBEEF, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1});
        step('{1'b1, 6'b110000, 1'b0, 5'd4, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0},
             '{5'd9, 1'b1, 32'hDEADBEEF, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1});
        // Flush coincident with pending LL write of 1: flush wins
        step('{1'b1, 6'b000000, 1'b1, 5'd6, 1'b1, 32'h77777777, 32'h8, 32'h9, 1'b1, 1'b1, 1'b1},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        // All-ones pattern with LL
        step('{1'b1, 6'b000000, 1'b0, 5'd31, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b1},
             '{5'd31, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0});
        // Flush with both stalls: bubble, LLbit cleared
        step('{1'b1, 6'b110000, 1'b1, 5'd1, 1'b1, 32'h1, 32'h1, 32'h1, 1'b1, 1'b1, 1'b1},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        // LL then plain traffic: LLbit set two cycles later and held
        step('{1'b1, 6'b000000, 1'b0, 5'd2, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1},
             '{5'd2, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0});
        step('{1'b1, 6'b000000, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        step('{1'b1, 6'b000000, 1'b0, 5'd4, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0},
             '{5'd4, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1});
        // Reset mid-stall with wb_wdata=DEADBEEF and LLbit_o=1: reset wins
        step('{1'b0, 6'b110000, 1'b0, 5'd8, 1'b1, 32'h13579BDF, 32'h3, 32'h4, 1'b1, 1'b1, 1'b1},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        // Out of reset: LL write of 0
        step('{1'b1, 6'b000000, 1'b0, 5'd10, 1'b1, 32'h0BADCAFE, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0},
             '{5'd10, 1'b1, 32'h0BADCAFE, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0, 1'b0});
        step('{1'b1, 6'b001111, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0},
             '{5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
